// File: rtl/wl_fifo_pkg.sv
// Shared FIFO storage definitions: default geometry and the even-parity helper.
package wl_fifo_pkg;

    localparam int WL_L       = 3;
    localparam int WL_W       = 8;
    localparam int WL_PAR_MAX = 64;

    function automatic logic wl_parity(input logic [WL_PAR_MAX-1:0] dat);
        return ^dat;
    endfunction

endpackage

// File: rtl/wl_afifo_ram_array_if.sv
// FIFO RAM control bundle: mapper-side request strobes in, registered read data and sticky errors back.
import wl_fifo_pkg::*;

interface wl_afifo_ram_array_if #(
    parameter int L = WL_L,
    parameter int W = WL_W
);
    logic         we_ram;
    logic         re_ram;
    logic [L-1:0] waddr;
    logic [L-1:0] raddr;
    logic [W-1:0] wdata;
    logic         inj_par_err;
    logic         err_clr;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         unwr_err;
    logic         par_err;

    modport master (
        output we_ram, re_ram, waddr, raddr, wdata, inj_par_err, err_clr,
        input  rdata, rvalid, unwr_err, par_err
    );

    modport slave (
        input  we_ram, re_ram, waddr, raddr, wdata, inj_par_err, err_clr,
        output rdata, rvalid, unwr_err, par_err
    );
endinterface

// File: rtl/wl_afifo_ram_par.sv
// Combinational even-parity generate (write side) and check (read side); zero latency, no flow control.
import wl_fifo_pkg::*;

module wl_afifo_ram_par #(
    parameter int W = WL_W
) (
    input  logic [W-1:0] wdata,
    input  logic         inj_par_err,
    output logic         wpar,
    input  logic [W-1:0] chk_dat,
    input  logic         chk_par,
    output logic         mismatch
);
    // Zero-extension leaves the reduction XOR unchanged, so one helper serves any W.
    assign wpar     = wl_parity(WL_PAR_MAX'(wdata)) ^ inj_par_err;
    assign mismatch = wl_parity(WL_PAR_MAX'(chk_dat)) ^ chk_par;
endmodule

// File: rtl/wl_afifo_ram_array.sv
// 2**L x W FIFO storage, 1-cycle registered read, write-first forwarding, no backpressure (accepts every cycle).
// Parity protection compiled in with WL_AFIFO_RAM_PARITY_EN.
import wl_fifo_pkg::*;

module wl_afifo_ram_array #(
    parameter int L = WL_L,
    parameter int W = WL_W
) (
    input logic                  clk,
    input logic                  rst,
    wl_afifo_ram_array_if.slave  bus
);
    localparam int D = 1 << L;
`ifdef WL_AFIFO_RAM_PARITY_EN
    localparam int DW = W + 1;
`else
    localparam int DW = W;
`endif

    logic [DW-1:0] mem [D];
    logic [D-1:0]  written;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_word;
    logic          fwd;
    logic          rd_hit;
    logic          rd_perr;
    logic [W-1:0]  rdata_q;
    logic          rvalid_q;
    logic          unwr_q;
    logic          par_q;

`ifdef WL_AFIFO_RAM_PARITY_EN
    logic wpar;

    wl_afifo_ram_par #(.W(W)) u_par (
        .wdata       (bus.wdata),
        .inj_par_err (bus.inj_par_err),
        .wpar        (wpar),
        .chk_dat     (rd_word[W-1:0]),
        .chk_par     (rd_word[W]),
        .mismatch    (rd_perr)
    );

    assign wr_word = {wpar, bus.wdata};
`else
    logic unused_inj;

    assign unused_inj = bus.inj_par_err;
    assign wr_word    = bus.wdata;
    assign rd_perr    = 1'b0;
`endif

    // Same-address collision forwards the incoming word, parity bit included.
    assign fwd     = bus.we_ram && bus.re_ram && (bus.waddr == bus.raddr);
    assign rd_word = fwd ? wr_word : mem[bus.raddr];
    assign rd_hit  = fwd || written[bus.raddr];

    always_ff @(posedge clk) begin
        if (bus.we_ram) begin
            mem[bus.waddr] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            unwr_q   <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            if (bus.we_ram) begin
                written[bus.waddr] <= 1'b1;
            end
            rvalid_q <= bus.re_ram;
            if (bus.re_ram) begin
                rdata_q <= rd_hit ? rd_word[W-1:0] : '0;
            end
            // A new error event outranks a clear in the same cycle.
            unwr_q <= (bus.re_ram && !rd_hit) || (unwr_q && !bus.err_clr);
            par_q  <= (bus.re_ram && rd_hit && rd_perr) || (par_q && !bus.err_clr);
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.unwr_err = unwr_q;
    assign bus.par_err  = par_q;
endmodule

// File: tb/tb_wl_afifo_ram_array.sv
// Bench for wl_afifo_ram_array: vector table plus read-data scoreboard, with reset corner sequences.
module tb_wl_afifo_ram_array;
    import wl_fifo_pkg::*;

`ifdef WL_AFIFO_RAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    typedef struct packed {
        logic       we;
        logic       re;
        logic [2:0] waddr;
        logic [2:0] raddr;
        logic [7:0] wdata;
        logic       inj;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_unwr;
        logic       exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb [$];
    vec_t vecs [$];

    wl_afifo_ram_array_if #(.L(3), .W(8)) bus ();

    wl_afifo_ram_array #(.L(3), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [2:0] wa,
                                input logic [2:0] ra, input logic [7:0] wd, input logic inj,
                                input logic clr, input logic ev, input logic [7:0] ed,
                                input logic eu, input logic ep);
        vec_t v;
        v.we = we; v.re = re; v.waddr = wa; v.raddr = ra; v.wdata = wd;
        v.inj = inj; v.clr = clr; v.exp_valid = ev; v.exp_data = ed;
        v.exp_unwr = eu; v.exp_par = ep;
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        bus.we_ram      = v.we;
        bus.re_ram      = v.re;
        bus.waddr       = v.waddr;
        bus.raddr       = v.raddr;
        bus.wdata       = v.wdata;
        bus.inj_par_err = v.inj;
        bus.err_clr     = v.clr;
    endtask

    // Reads push their expected word; rdata is checked against the queue only when rvalid strobes.
    task automatic step(input string name, input vec_t v);
        logic [7:0] exp;
        set_inputs(v);
        if (v.re) sb.push_back(v.exp_data);
        @(posedge clk);
        #1;
        chk({name, ".rvalid"}, 32'(bus.rvalid), 32'(v.exp_valid));
        if (bus.rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.rdata: rvalid with no read outstanding, got 0x%0h", name, bus.rdata);
            end else begin
                exp = sb.pop_front();
                chk({name, ".rdata"}, 32'(bus.rdata), 32'(exp));
            end
        end else begin
            chk({name, ".rdata_hold"}, 32'(bus.rdata), 32'(v.exp_data));
        end
        chk({name, ".unwr_err"}, 32'(bus.unwr_err), 32'(v.exp_unwr));
        chk({name, ".par_err"}, 32'(bus.par_err), 32'(v.exp_par));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({name, ".rdata"}, 32'(bus.rdata), 32'd0);
        chk({name, ".unwr_err"}, 32'(bus.unwr_err), 32'd0);
        chk({name, ".par_err"}, 32'(bus.par_err), 32'd0);
    endtask

    initial begin
        //            we re wa ra wdata inj clr  ev  edata  eu  ep
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 3, 0, 8'hA5, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3, 8'h00, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk(1, 1, 5, 5, 8'h3C, 0, 0, 1, 8'h3C, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 0));
        vecs.push_back(mk(0, 1, 0, 7, 8'h00, 0, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 1, 1, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 4, 3, 8'h77, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4, 8'h00, 0, 0, 1, 8'h77, 0, 0));
        vecs.push_back(mk(1, 0, 2, 0, 8'hFF, 1, 0, 0, 8'h77, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 8'h00, 0, 0, 1, 8'hFF, 0, PAR));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, PAR));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'hFF, 0, 0));
        vecs.push_back(mk(1, 1, 6, 6, 8'h01, 1, 0, 1, 8'h01, 0, PAR));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h01, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 3'(i), 0, 8'(8'h10 + i), 0, 0, 0, 8'h01, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 0, 3'(i), 8'h00, 0, 0, 1, 8'(8'h10 + i), 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h17, 0, 0));

        set_inputs(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Mid-read reset: strobe dropped, written bitmap cleared, parity skipped on unwritten data.
        step("pre_rst_wr", mk(1, 0, 2, 0, 8'hFF, 1, 0, 0, 8'h17, 0, 0));
        set_inputs(mk(0, 1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst_edge");
        rst = 1'b0;
        step("post_rst_idle", mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        step("post_rst_rd2", mk(0, 1, 0, 2, 8'h00, 0, 0, 1, 8'h00, 1, 0));
        step("post_rst_rd3", mk(0, 1, 0, 3, 8'h00, 0, 1, 1, 8'h00, 1, 0));
        step("post_rst_clr", mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
